// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode constants: word width, the nop encoding and the opcode map.
package fetch_queue_pkg;

  localparam int WORD_W = 16;
  localparam int AW_DEF = 16;
  localparam logic [WORD_W-1:0] NOP_INSN = 16'h000F;

  // Opcode field occupies the top nibble of an instruction word.
  typedef enum logic [3:0] {
    OPadd  = 4'h0,
    OPsub  = 4'h1,
    OPand  = 4'h2,
    OPor   = 4'h3,
    OPld   = 4'h4,
    OPst   = 4'h5,
    OPli   = 4'h6,
    OPbeq  = 4'h7,
    OPjump = 4'h8,
    OPcall = 4'h9,
    OPret  = 4'hA,
    OPsys  = 4'hF
  } opcode_e;

  function automatic opcode_e insn_opcode(input logic [WORD_W-1:0] insn);
    return opcode_e'(insn[WORD_W-1 -: 4]);
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Prefetch FIFO of {pc, word} entries with wrapping pointers and a single-cycle flush.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: owns the fetch PC, issues one-word reads and hands buffered words to decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     halt,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirect_pc,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic [WORD_W-1:0]        imem_data,
  output logic [WORD_W-1:0]        ir,
  output logic [AW-1:0]            ir_pc,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]     fpc_q, fpc_d;
  logic              inflight_q, inflight_d;
  logic [AW-1:0]     inflight_pc_q, inflight_pc_d;
  logic              redirect_eff;
  logic              push;
  logic              pop;
  logic              has_credit;
  logic [CW:0]       used;
  logic [CW-1:0]     fifo_count;
  logic [AW+WORD_W-1:0] head;

  assign redirect_eff = redirect && !halt;

  // Credit counts the in-flight word so a halted response always has room.
  assign used       = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign has_credit = used < (CW+1)'(DEPTH);

  always_comb begin
    imem_req  = !reset && !halt && (redirect || has_credit);
    imem_addr = redirect ? redirect_pc : fpc_q;
    ir_valid  = !reset && !redirect_eff && (fifo_count != '0);
    ir        = ir_valid ? head[WORD_W-1:0] : NOP_INSN;
    ir_pc     = ir_valid ? head[AW+WORD_W-1 -: AW] : '0;
    push      = inflight_q && !redirect_eff && !reset;
    pop       = ir_valid && ir_ready && !halt;
  end

  always_comb begin
    fpc_d         = fpc_q;
    inflight_d    = imem_req;
    inflight_pc_d = inflight_pc_q;
    if (imem_req) begin
      fpc_d         = imem_addr + 1'b1;
      inflight_pc_d = imem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + WORD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_eff),
    .wdata ({inflight_pc_q, imem_data}),
    .rdata (head),
    .count (fifo_count)
  );

  assign count = fifo_count;

endmodule
